fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch front end of the CPU: owns the architectural PC register, issues word fetches to instruction memory over a valid/ready request and valid response channel, and buffers returned instructions in a small FIFO for decode. It consumes the next-PC computation as its redirect input (target plus valid) and produces each instruction's PC and PC+4. PC+4 is the value the next-PC logic uses as its base.

## Interface
- RESET_PC, 32'h0000_3000, PC value loaded on reset; bits [1:0] must be 0.
- FIFO_DEPTH, 2, instruction buffer entries; legal values 2 or 4.
- clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- redirect_valid  input  1  control flow change this cycle; has priority over everything except reset.
- redirect_pc  input  32  redirect target; used as {redirect_pc[31:2],2'b00}.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  32  word-aligned fetch address.
- imem_rsp_valid  input  1  response data valid; one pulse per accepted request.
- imem_rsp_data  input  32  fetched instruction.
- inst_valid  output  1  FIFO head valid.
- inst_ready  input  1  decode consumes head.
- inst_data  output  32  head instruction.
- inst_pc  output  32  head instruction address.
- inst_pc4  output  32  inst_pc + 4, wrap modulo 2^32.

## Operation
- Registers:
  - pc: next address to request.
  - req_pc: address of the outstanding request.
  - FIFO of {pc, instruction} entries with count.
  - state.
- States:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding, result wanted.
  - DROP: one request outstanding, result stale.
- At most one request is outstanding at any time.
- imem_req_valid = (state==IDLE) && (count < FIFO_DEPTH). imem_req_addr = pc. Both are driven combinationally from registers only, never from redirect_valid.
- Request handshake: imem_req_valid && imem_req_ready.
  - On handshake: req_pc <= pc, pc <= pc+4 (wraps), and state becomes WAIT, or DROP if redirect_valid is high in the same cycle.
- In WAIT, imem_rsp_valid pushes {req_pc, imem_rsp_data} and the state becomes IDLE. If redirect_valid is high in the same cycle, the data is discarded (no push) and the state still becomes IDLE.
- In DROP, imem_rsp_valid discards the data and the state becomes IDLE.
- imem_rsp_valid while in IDLE is a protocol violation. It is ignored.
- The FIFO cannot overflow: requests are issued only with count < FIFO_DEPTH and one outstanding. A push may coincide with a pop; count is then unchanged.
- Pop: inst_valid && inst_ready. inst_valid = (count != 0). The head outputs are taken directly from FIFO storage.
- Redirect (redirect_valid=1, not reset):
  - pc <= aligned redirect_pc.
  - FIFO is flushed: count=0, read and write pointers reset.
  - WAIT becomes DROP. IDLE stays IDLE unless a request handshakes the same cycle (see above).
  - Any concurrent pop is void; decode must treat the head as killed.
- Reset has priority over redirect and all handshakes.
  - pc=RESET_PC, state=IDLE, FIFO empty.
  - Any in-flight response arriving after reset deasserts is dropped, because the state is IDLE.

## Timing
- Reset values:
  - imem_req_valid=0 while reset=1, then 1 in the first cycle after reset.
  - imem_req_addr=RESET_PC.
  - inst_valid=0.
  - inst_data, inst_pc and inst_pc4 are don't-care while inst_valid=0.
- Memory latency: the response comes at least 1 cycle after the request handshake, with arbitrary additional latency.
- Throughput: one instruction per (memory latency + 1) cycles, because requests are blocking.
- Push to inst_valid: the entry is visible the cycle after the response cycle.
- Redirect to new request: the new target is requested in the cycle after the redirect if the state is IDLE. Otherwise it is requested the cycle after the stale response is dropped.
- Redirect to inst_valid: inst_valid=0 in the cycle after the redirect.

## Test plan
- Reset with imem_req_ready=1, memory latency 1, inst_ready=1:
  - requests go to 0x3000, 0x3004 and 0x3008 in order;
  - inst_pc sequence is 0x3000, 0x3004, 0x3008;
  - inst_pc4 is 0x3004 at the first instruction.
- Backpressure with inst_ready=0 and FIFO_DEPTH=2: exactly 2 entries are captured, then imem_req_valid=0. Raising inst_ready for 1 cycle produces exactly one new request, at 0x3008.
- Redirect to 0x0000_4000 while in WAIT for 0x3004: the 0x3004 data is dropped, FIFO is empty the next cycle, the next request goes to 0x4000, and the next inst_pc is 0x4000.
- Redirect to 0x0000_5003 in the same cycle as a request handshake for 0x3008 and a pop: the 0x3008 response is discarded, the next request goes to 0x5000, and no 0x3008 entry ever appears.
- Redirect in the same cycle as a response arriving in WAIT: the response is not pushed and the next request goes to the redirect target.
- Reset asserted while in WAIT with a response 3 cycles later:
  - the outputs return to their reset values;
  - the late response is ignored;
  - the first inst_pc after reset is RESET_PC;
  - pc wrap check: redirect to 0xFFFF_FFFC produces inst_pc4 = 0x0000_0000.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end: PC register, blocking imem fetch, instruction FIFO
//
// Owns the architectural fetch PC and issues one word fetch at a time. Each
// returned instruction is tagged with its address and buffered for decode.
// A redirect retargets the PC, flushes the buffer and discards any in-flight
// response.
//
// Ports:
//   clk, reset                  clock; synchronous active-high reset
//   redirect_valid, redirect_pc control-flow change and its target
//   imem_req_valid/ready/addr   fetch request channel
//   imem_rsp_valid/data         fetch response, one pulse per accepted request
//   inst_valid/ready            decode handshake on the buffer head
//   inst_data, inst_pc, inst_pc4 head instruction, its address, address + 4

module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc4
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // nothing outstanding
    WAIT = 2'd1,  // one request outstanding, its data is wanted
    DROP = 2'd2   // one request outstanding, its data is stale
  } state_t;

  state_t            state;
  logic [31:0]       pc;
  logic [31:0]       req_pc;
  logic [31:0]       fifo_pc   [FIFO_DEPTH];
  logic [31:0]       fifo_inst [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic req_fire;
  logic push;
  logic pop;
  logic [31:0] redirect_target;
  logic unused_redirect_low;

  assign redirect_target     = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_low = ^redirect_pc[1:0];

  // Request valid depends only on state registers; the reset term keeps the
  // channel quiet while reset is held, regardless of the register contents.
  assign imem_req_valid = !reset && (state == IDLE) && (count < CNT_W'(FIFO_DEPTH));
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response that coincides with a redirect belongs to the old path.
  assign push = (state == WAIT) && imem_rsp_valid && !redirect_valid;
  assign pop  = inst_valid && inst_ready;

  assign inst_valid = (count != '0);
  assign inst_data  = fifo_inst[rd_ptr];
  assign inst_pc    = fifo_pc[rd_ptr];
  assign inst_pc4   = fifo_pc[rd_ptr] + 32'd4;

  // Control state: PC, outstanding request tracking and FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (req_fire) begin
        req_pc <= pc;
        pc     <= pc + 32'd4;
      end
      // Redirect overrides the sequential increment.
      if (redirect_valid) begin
        pc <= redirect_target;
      end

      case (state)
        IDLE: begin
          // A response here is a protocol violation and is ignored.
          if (req_fire) begin
            state <= redirect_valid ? DROP : WAIT;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            state <= IDLE;
          end else if (redirect_valid) begin
            state <= DROP;
          end
        end
        DROP: begin
          if (imem_rsp_valid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (redirect_valid) begin
        // Flush voids any concurrent pop and the (already suppressed) push.
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Buffer storage needs no reset: entries are only read while count != 0.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= req_pc;
      fifo_inst[wr_ptr] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit

module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc4;

  int checks   = 0;
  int failures = 0;

  fetch_unit #(
    .RESET_PC   (32'h0000_3000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_pc4       (inst_pc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        rspv;
    logic [31:0] rspd;
    logic        irdy;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_pc;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic rst, input logic redir, input logic [31:0] rpc,
                             input logic rdy, input logic rspv, input logic [31:0] rspd,
                             input logic irdy, input logic e_rv, input logic [31:0] e_addr,
                             input logic e_iv, input logic [31:0] e_pc, input logic [31:0] e_data);
    vec_t t;
    t.rst = rst; t.redir = redir; t.rpc = rpc; t.rdy = rdy; t.rspv = rspv; t.rspd = rspd;
    t.irdy = irdy; t.e_rv = e_rv; t.e_addr = e_addr; t.e_iv = e_iv; t.e_pc = e_pc;
    t.e_data = e_data;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive inputs after the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic rst, input logic redir, input logic [31:0] rpc,
                       input logic rdy, input logic rspv, input logic [31:0] rspd,
                       input logic irdy);
    @(negedge clk);
    reset          = rst;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    imem_rsp_valid = rspv;
    imem_rsp_data  = rspd;
    inst_ready     = irdy;
    #1;
  endtask

  task automatic check_outs(input string tag, input logic e_rv, input logic [31:0] e_addr,
                            input logic e_iv, input logic [31:0] e_pc, input logic [31:0] e_data);
    chk({tag, " req_valid"}, {31'b0, imem_req_valid}, {31'b0, e_rv});
    chk({tag, " req_addr"}, imem_req_addr, e_addr);
    chk({tag, " inst_valid"}, {31'b0, inst_valid}, {31'b0, e_iv});
    if (e_iv) begin
      chk({tag, " inst_pc"}, inst_pc, e_pc);
      chk({tag, " inst_data"}, inst_data, e_data);
      chk({tag, " inst_pc4"}, inst_pc4, e_pc + 32'd4);
    end
  endtask

  initial begin
    bit found;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; inst_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state
    vecs.push_back(v(1,0,0,        0,0,0,          0, 0,32'h3000,0,0,0));
    // Streaming, latency 1, decode always ready
    vecs.push_back(v(0,0,0,        1,0,0,          1, 1,32'h3000,0,0,0));
    vecs.push_back(v(0,0,0,        1,1,32'hA0,     1, 0,32'h3004,0,0,0));
    vecs.push_back(v(0,0,0,        1,0,0,          1, 1,32'h3004,1,32'h3000,32'hA0));
    vecs.push_back(v(0,0,0,        1,1,32'hA1,     1, 0,32'h3008,0,0,0));
    vecs.push_back(v(0,0,0,        1,0,0,          1, 1,32'h3008,1,32'h3004,32'hA1));
    vecs.push_back(v(0,0,0,        1,1,32'hA2,     1, 0,32'h300C,0,0,0));
    vecs.push_back(v(0,0,0,        0,0,0,          1, 1,32'h300C,1,32'h3008,32'hA2));
    vecs.push_back(v(1,0,0,        0,0,0,          0, 0,32'h300C,0,0,0));
    vecs.push_back(v(1,0,0,        0,0,0,          0, 0,32'h3000,0,0,0));
    // Backpressure: two entries fill the buffer, one pop allows one request
    vecs.push_back(v(0,0,0,        1,0,0,          0, 1,32'h3000,0,0,0));
    vecs.push_back(v(0,0,0,        1,1,32'hB0,     0, 0,32'h3004,0,0,0));
    vecs.push_back(v(0,0,0,        1,0,0,          0, 1,32'h3004,1,32'h3000,32'hB0));
    vecs.push_back(v(0,0,0,        1,1,32'hB1,     0, 0,32'h3008,1,32'h3000,32'hB0));
    vecs.push_back(v(0,0,0,        1,0,0,          0, 0,32'h3008,1,32'h3000,32'hB0));
    vecs.push_back(v(0,0,0,        1,0,0,          1, 0,32'h3008,1,32'h3000,32'hB0));
    vecs.push_back(v(0,0,0,        1,0,0,          0, 1,32'h3008,1,32'h3004,32'hB1));
    vecs.push_back(v(0,0,0,        1,1,32'hB2,     0, 0,32'h300C,1,32'h3004,32'hB1));
    vecs.push_back(v(0,0,0,        1,0,0,          0, 0,32'h300C,1,32'h3004,32'hB1));
    vecs.push_back(v(1,0,0,        0,0,0,          0, 0,32'h300C,1,32'h3004,32'hB1));
    vecs.push_back(v(1,0,0,        0,0,0,          0, 0,32'h3000,0,0,0));
    // Redirect to 0x4000 while waiting for 0x3004
    vecs.push_back(v(0,0,0,        1,0,0,          1, 1,32'h3000,0,0,0));
    vecs.push_back(v(0,0,0,        0,1,32'hC0,     0, 0,32'h3004,0,0,0));
    vecs.push_back(v(0,0,0,        1,0,0,          0, 1,32'h3004,1,32'h3000,32'hC0));
    vecs.push_back(v(0,1,32'h4000, 0,0,0,          0, 0,32'h3008,1,32'h3000,32'hC0));
    vecs.push_back(v(0,0,0,        1,1,32'hC1,     1, 0,32'h4000,0,0,0));
    vecs.push_back(v(0,0,0,        1,0,0,          1, 1,32'h4000,0,0,0));
    vecs.push_back(v(0,0,0,        0,1,32'hC4,     1, 0,32'h4004,0,0,0));
    vecs.push_back(v(0,0,0,        0,0,0,          1, 1,32'h4004,1,32'h4000,32'hC4));
    vecs.push_back(v(1,0,0,        0,0,0,          0, 0,32'h4004,0,0,0));
    vecs.push_back(v(1,0,0,        0,0,0,          0, 0,32'h3000,0,0,0));
    // Redirect to 0x5003 together with a handshake for 0x3008 and a pop
    vecs.push_back(v(0,0,0,        1,0,0,          0, 1,32'h3000,0,0,0));
    vecs.push_back(v(0,0,0,        0,1,32'hD0,     0, 0,32'h3004,0,0,0));
    vecs.push_back(v(0,0,0,        1,0,0,          0, 1,32'h3004,1,32'h3000,32'hD0));
    vecs.push_back(v(0,0,0,        0,1,32'hD1,     0, 0,32'h3008,1,32'h3000,32'hD0));
    vecs.push_back(v(0,0,0,        1,0,0,          1, 0,32'h3008,1,32'h3000,32'hD0));
    vecs.push_back(v(0,1,32'h5003, 1,0,0,          1, 1,32'h3008,1,32'h3004,32'hD1));
    vecs.push_back(v(0,0,0,        1,1,32'hD2,     1, 0,32'h5000,0,0,0));
    vecs.push_back(v(0,0,0,        1,0,0,          1, 1,32'h5000,0,0,0));
    vecs.push_back(v(0,0,0,        0,1,32'hD5,     1, 0,32'h5004,0,0,0));
    vecs.push_back(v(0,0,0,        0,0,0,          1, 1,32'h5004,1,32'h5000,32'hD5));
    vecs.push_back(v(1,0,0,        0,0,0,          0, 0,32'h5004,0,0,0));
    vecs.push_back(v(1,0,0,        0,0,0,          0, 0,32'h3000,0,0,0));
    // Redirect to 0x6000 coinciding with the response in WAIT
    vecs.push_back(v(0,0,0,        1,0,0,          1, 1,32'h3000,0,0,0));
    vecs.push_back(v(0,1,32'h6000, 0,1,32'hE0,     1, 0,32'h3004,0,0,0));
    vecs.push_back(v(0,0,0,        1,0,0,          1, 1,32'h6000,0,0,0));
    vecs.push_back(v(0,0,0,        0,1,32'hE6,     1, 0,32'h6004,0,0,0));
    vecs.push_back(v(0,0,0,        0,0,0,          1, 1,32'h6004,1,32'h6000,32'hE6));
    vecs.push_back(v(1,0,0,        0,0,0,          0, 0,32'h6004,0,0,0));
    vecs.push_back(v(1,0,0,        0,0,0,          0, 0,32'h3000,0,0,0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].redir, vecs[i].rpc, vecs[i].rdy, vecs[i].rspv,
            vecs[i].rspd, vecs[i].irdy);
      check_outs($sformatf("row%0d", i), vecs[i].e_rv, vecs[i].e_addr, vecs[i].e_iv,
                 vecs[i].e_pc, vecs[i].e_data);
    end

    // Reset while in WAIT; the stale response arrives 3 cycles later
    drive(0,0,0, 1,0,0, 0);
    check_outs("rw_req", 1, 32'h3000, 0, 0, 0);
    drive(1,0,0, 0,0,0, 0);
    check_outs("rw_rst0", 0, 32'h3004, 0, 0, 0);
    drive(1,0,0, 0,0,0, 0);
    check_outs("rw_rst1", 0, 32'h3000, 0, 0, 0);
    drive(0,0,0, 0,0,0, 0);
    check_outs("rw_post0", 1, 32'h3000, 0, 0, 0);
    drive(0,0,0, 0,1,32'hDEAD_BEEF, 0);
    check_outs("rw_late", 1, 32'h3000, 0, 0, 0);
    drive(0,0,0, 1,0,0, 0);
    check_outs("rw_ignored", 1, 32'h3000, 0, 0, 0);
    drive(0,0,0, 0,1,32'h0000_0F01, 0);
    check_outs("rw_wait", 0, 32'h3004, 0, 0, 0);
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      drive(0,0,0, 0,0,0, 0);
      if (inst_valid) begin
        found = 1'b1;
        check_outs("rw_first", 1, 32'h3004, 1, 32'h3000, 32'h0000_0F01);
      end
    end
    chk("rw_first_seen", {31'b0, found}, 32'd1);

    // PC wrap: redirect to 0xFFFF_FFFC
    drive(1,0,0, 0,0,0, 0);
    drive(1,0,0, 0,0,0, 0);
    drive(0,1,32'hFFFF_FFFC, 0,0,0, 0);
    check_outs("wrap_redir", 1, 32'h3000, 0, 0, 0);
    drive(0,0,0, 1,0,0, 0);
    check_outs("wrap_req", 1, 32'hFFFF_FFFC, 0, 0, 0);
    drive(0,0,0, 0,1,32'h0000_00F7, 0);
    check_outs("wrap_pc", 0, 32'h0000_0000, 0, 0, 0);
    drive(0,0,0, 0,0,0, 1);
    check_outs("wrap_head", 1, 32'h0000_0000, 1, 32'hFFFF_FFFC, 32'h0000_00F7);
    chk("wrap_pc4_zero", inst_pc4, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
